// File: rtl/timer_pkg.sv
// Shared address map, limits and register-select encoding for the per-hart timer registers.
package timer_pkg;

   localparam logic [7:0]  INTR_ENABLE_OFFSET = 8'h00;
   localparam logic [7:0]  INTR_STATE_OFFSET  = 8'h04;
   localparam logic [7:0]  INTR_TEST_OFFSET   = 8'h08;
   localparam logic [7:0]  MTIME_LO_OFFSET    = 8'h0C;
   localparam logic [7:0]  MTIME_HI_OFFSET    = 8'h10;
   localparam logic [7:0]  MTIMECMP_BASE      = 8'h20;
   localparam int unsigned MTIMECMP_STRIDE    = 8;
   localparam int unsigned MAX_N              = 8;

   typedef enum logic [2:0] {
      SEL_ENABLE,
      SEL_STATE,
      SEL_TEST,
      SEL_MTIME_LO,
      SEL_MTIME_HI,
      SEL_CMP_LO,
      SEL_CMP_HI,
      SEL_NONE
   } reg_sel_e;

endpackage

// File: rtl/timer_intr_reg.sv
// Sticky interrupt state with enable, W1C and test-set; intr_o comes straight from a flop.
module timer_intr_reg #(
   parameter int unsigned N = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] intr_raw_i,
   input  logic         enable_we_i,
   input  logic [N-1:0] enable_wdata_i,
   input  logic [N-1:0] w1c_i,
   input  logic [N-1:0] test_i,
   output logic [N-1:0] enable_o,
   output logic [N-1:0] state_o,
   output logic [N-1:0] intr_o
);

   logic [N-1:0] enable_q, enable_d;
   logic [N-1:0] state_q, state_d;
   logic [N-1:0] intr_q, intr_d;

   always_comb begin
      enable_d = enable_we_i ? enable_wdata_i : enable_q;
      // Set sources win over a same-cycle clear.
      state_d  = (state_q & ~w1c_i) | intr_raw_i | test_i;
      intr_d   = state_d & enable_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         enable_q <= '0;
         state_q  <= '0;
         intr_q   <= '0;
      end else begin
         enable_q <= enable_d;
         state_q  <= state_d;
         intr_q   <= intr_d;
      end
   end

   assign enable_o = enable_q;
   assign state_o  = state_q;
   assign intr_o   = intr_q;

endmodule

// File: rtl/timer_hart_regs.sv
// One hart's mtime/mtimecmp registers, interrupt state and a single-cycle 32-bit register port.
module timer_hart_regs
   import timer_pkg::*;
#(
   parameter int unsigned N = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                tick,
   input  logic [63:0]         mtime_d,
   input  logic [N-1:0]        intr_raw,
   output logic [63:0]         mtime,
   output logic [N-1:0][63:0]  mtimecmp,
   input  logic                reg_re,
   input  logic                reg_we,
   input  logic [7:0]          reg_addr,
   input  logic [31:0]         reg_wdata,
   output logic                reg_ack,
   output logic [31:0]         reg_rdata,
   output logic                reg_error,
   output logic [N-1:0]        intr_o
);

   logic [63:0]        cur_time_q, cur_time_d;
   logic [31:0]        shadow_q, shadow_d;
   logic [N-1:0][63:0] cmp_q, cmp_d;
   logic               ack_q, ack_d;
   logic               error_q, error_d;
   logic [31:0]        rdata_q, rdata_d;

   reg_sel_e    sel;
   logic [7:0]  addr_w, cmp_off;
   logic [2:0]  cmp_idx;
   logic        access, err, wr, rd;
   logic [31:0] rmux;
   logic [N-1:0] intr_enable, intr_state, w1c, test;

   always_comb begin
      addr_w  = {reg_addr[7:2], 2'b00};
      cmp_off = addr_w - MTIMECMP_BASE;
      cmp_idx = cmp_off[5:3];
      sel     = SEL_NONE;
      case (addr_w)
         INTR_ENABLE_OFFSET: sel = SEL_ENABLE;
         INTR_STATE_OFFSET:  sel = SEL_STATE;
         INTR_TEST_OFFSET:   sel = SEL_TEST;
         MTIME_LO_OFFSET:    sel = SEL_MTIME_LO;
         MTIME_HI_OFFSET:    sel = SEL_MTIME_HI;
         default: begin
            if (addr_w >= MTIMECMP_BASE &&
                addr_w < MTIMECMP_BASE + 8'(MAX_N * MTIMECMP_STRIDE) &&
                32'(cmp_idx) < N) begin
               sel = cmp_off[2] ? SEL_CMP_HI : SEL_CMP_LO;
            end
         end
      endcase
      access = reg_re | reg_we;
      err    = (reg_re & reg_we) | (sel == SEL_NONE);
      wr     = reg_we & ~err;
      rd     = reg_re & ~err;
   end

   always_comb begin
      cur_time_d = cur_time_q;
      shadow_d   = shadow_q;
      cmp_d      = cmp_q;
      rmux       = '0;

      // A software write to either half drops any same-cycle tick.
      if (wr && sel == SEL_MTIME_LO) begin
         cur_time_d[31:0] = reg_wdata;
      end else if (wr && sel == SEL_MTIME_HI) begin
         cur_time_d[63:32] = reg_wdata;
      end else if (tick) begin
         cur_time_d = mtime_d;
      end

      if (rd && sel == SEL_MTIME_LO) shadow_d = cur_time_q[63:32];

      for (int t = 0; t < int'(N); t++) begin
         if (cmp_idx == t[2:0]) begin
            if (wr && sel == SEL_CMP_LO) cmp_d[t][31:0]  = reg_wdata;
            if (wr && sel == SEL_CMP_HI) cmp_d[t][63:32] = reg_wdata;
            if (sel == SEL_CMP_LO) rmux = cmp_q[t][31:0];
            if (sel == SEL_CMP_HI) rmux = cmp_q[t][63:32];
         end
      end

      case (sel)
         SEL_ENABLE:   rmux = 32'(intr_enable);
         SEL_STATE:    rmux = 32'(intr_state);
         SEL_MTIME_LO: rmux = cur_time_q[31:0];
         SEL_MTIME_HI: rmux = shadow_q;
         default:      ;
      endcase

      ack_d   = access;
      error_d = access & err;
      rdata_d = rd ? rmux : '0;
   end

   always_comb begin
      w1c  = (wr && sel == SEL_STATE) ? reg_wdata[N-1:0] : '0;
      test = (wr && sel == SEL_TEST)  ? reg_wdata[N-1:0] : '0;
   end

   timer_intr_reg #(
      .N (N)
   ) u_intr (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .intr_raw_i     (intr_raw),
      .enable_we_i    (wr && sel == SEL_ENABLE),
      .enable_wdata_i (reg_wdata[N-1:0]),
      .w1c_i          (w1c),
      .test_i         (test),
      .enable_o       (intr_enable),
      .state_o        (intr_state),
      .intr_o         (intr_o)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_time_q <= '0;
         shadow_q   <= '0;
         cmp_q      <= {N{64'hFFFF_FFFF_FFFF_FFFF}};
         ack_q      <= 1'b0;
         error_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         cur_time_q <= cur_time_d;
         shadow_q   <= shadow_d;
         cmp_q      <= cmp_d;
         ack_q      <= ack_d;
         error_q    <= error_d;
         rdata_q    <= rdata_d;
      end
   end

   assign mtime     = cur_time_q;
   assign mtimecmp  = cmp_q;
   assign reg_ack   = ack_q;
   assign reg_error = error_q;
   assign reg_rdata = rdata_q;

endmodule

// File: doc/timer_hart_regs.md
Name: timer_hart_regs

Overview:
- Register and state stage directly downstream of the timer core, one hart's worth.
- Holds the architectural 64-bit mtime and N mtimecmp registers, and feeds mtime/mtimecmp back into the core each cycle.
- Commits mtime_d on each core tick, turns the core's raw compare outputs into sticky interrupt-state bits with enable and test, and exposes all of it through a simple 32-bit register port.

Parameters:
- N, 1, number of comparators/interrupt vectors; legal range 1..8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- tick  in  1  core tick; commit mtime_d this cycle
- mtime_d  in  64  next mtime from core
- intr_raw  in  N  raw compare result from core (level)
- mtime  out  64  current mtime to core
- mtimecmp  out  N x 64  compare values to core
- reg_re  in  1  read strobe
- reg_we  in  1  write strobe
- reg_addr  in  8  byte address, bits [1:0] ignored
- reg_wdata  in  32  write data
- reg_ack  out  1  access complete
- reg_rdata  out  32  read data, valid with reg_ack
- reg_error  out  1  access error, valid with reg_ack
- intr_o  out  N  interrupt outputs to PLIC/core

Behaviour:
- Reset values:
  - mtime=0; mtimecmp[t]=64'hFFFF_FFFF_FFFF_FFFF; intr_state=0; intr_enable=0; hi-shadow=0.
  - reg_ack=0, reg_rdata=0, reg_error=0, intr_o=0.
- Address map:
  - 0x00 INTR_ENABLE (RW, bits [N-1:0]).
  - 0x04 INTR_STATE (R, W1C).
  - 0x08 INTR_TEST (W1S onto state, reads 0).
  - 0x0C MTIME_LO; 0x10 MTIME_HI.
  - 0x20+8t MTIMECMP_LO[t]; 0x24+8t MTIMECMP_HI[t].
  - Unused bits above N read 0; writes to them are ignored.
- Access timing:
  - Accepted every cycle; reg_ack pulses exactly 1 cycle after a cycle with reg_re|reg_we.
  - reg_rdata/reg_error are registered alongside reg_ack; reg_rdata=0 when reg_ack=0.
- Errors: unmapped address, comparator index >= N, or reg_re&reg_we in the same cycle.
  - reg_error=1 with the ack; no state change; reg_rdata=0.
- mtime update, in priority order:
  - SW write to MTIME_LO/HI replaces that half; the other half holds; any tick that cycle is dropped.
  - Otherwise, if tick, mtime<=mtime_d.
  - Wrap from 2^64-1 is whatever mtime_d gives; no special handling.
- Atomic read:
  - Reading MTIME_LO returns mtime[31:0] and captures mtime[63:32] into hi-shadow in the same cycle.
  - Reading MTIME_HI returns hi-shadow, not live mtime.
  - A read that coincides with a tick returns the pre-tick value.
- mtimecmp: written half-by-half with no intermediate masking; software writes HI=all-ones first by convention.
- Interrupts:
  - Each cycle, intr_state[t] <= (intr_state[t] & ~w1c[t]) | intr_raw[t] | test[t].
  - Set beats clear in the same cycle, so W1C has no effect while intr_raw is high.
  - intr_o = intr_state & intr_enable, driven straight from flops.
  - Latency: intr_raw high in cycle k → intr_o high in cycle k+1, if enabled.
  - Enabling a bit whose state is already set raises intr_o the cycle after the write.
- Reset mid-access: ack and any pending read data are lost; all state returns to its reset value.

Decomposition:
- timer_pkg holds:
  - address offset localparams (INTR_ENABLE_OFFSET … MTIMECMP_BASE, MTIMECMP_STRIDE=8);
  - MAX_N=8;
  - reg_sel_e enum (SEL_ENABLE, SEL_STATE, SEL_TEST, SEL_MTIME_LO, SEL_MTIME_HI, SEL_CMP_LO, SEL_CMP_HI, SEL_NONE).
- One sub-module: timer_intr_reg, parameterized by N, holding state/enable/test logic and producing intr_o; instantiated once.

Test Plan:
- Reset, then read every mapped register: ack 1 cycle after each read; mtime=0, cmp LO/HI=0xFFFFFFFF, state/enable=0, no error.
- Tick every cycle with mtime_d=mtime+1 from 0x0000_0000_FFFF_FFFE:
  - Read LO at 0xFFFF_FFFF, then HI two ticks later.
  - Expect LO=0xFFFFFFFF, HI=0x00000000 (shadow), with no torn read.
- Write MTIME_LO=0x1234 in the same cycle as tick with mtime_d=0x5_0000_0000: mtime becomes {old_hi, 0x1234}; tick dropped.
- N=2: drive intr_raw=2'b01 for one cycle with enable=0:
  - state=01, intr_o=00.
  - Write enable=01: intr_o=01 next cycle.
  - W1C 0x1 while raw=0: state=0, intr_o=0.
  - W1C while raw=1: state stays 1.
- Write INTR_TEST=0x2: state[1] set next cycle, intr_o[1] follows when enabled; INTR_TEST reads 0.
- N=2: read 0x30 (cmp index 2), plus reg_re&reg_we to 0x00:
  - reg_error=1 and rdata=0 on each ack; enable unchanged.
